// File: rtl/slave_fifo.sv
// slave_fifo: per-channel first-word-fall-through input buffer.
// Accepts slave words over valid/ready, presents the head word and a
// request to the downstream formatter, and reports free space as margin_o.
module slave_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int MARGIN_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   ch_data_i,
  input  logic                    ch_valid_i,
  output logic                    ch_ready_o,
  input  logic                    fetch_i,
  output logic                    slv_req_o,
  output logic [DATA_WIDTH-1:0]   slv_data_o,
  output logic [MARGIN_WIDTH-1:0] margin_o
);

  localparam int AW = $clog2(DEPTH);

  // Full-scale constants sized to the count and margin registers.
  localparam logic [AW:0]           C_DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [MARGIN_WIDTH-1:0] C_DEPTH_MRG = MARGIN_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;
  logic [MARGIN_WIDTH-1:0] r_margin;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [AW:0]             w_count_nxt;
  logic [MARGIN_WIDTH-1:0] w_margin_nxt;

  assign w_full  = (r_count == C_DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // A push needs the channel enabled and room; a pop needs a stored word,
  // so a fetch against an empty FIFO is silently ignored. Because ready is
  // low at full, a simultaneous push+pop at full only pops.
  assign ch_ready_o = en_i & ~w_full;
  assign w_push     = ch_valid_i & ch_ready_o;
  assign w_pop      = fetch_i & ~w_empty;

  assign slv_req_o  = ~w_empty;
  assign slv_data_o = r_mem[r_rd_ptr];
  assign margin_o   = r_margin;

  // Occupancy for the coming edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Margin is derived from the next count so it tracks count on the same edge.
  assign w_margin_nxt = C_DEPTH_MRG - MARGIN_WIDTH'(w_count_nxt);

  // Storage array: written on push, never reset (contents are don't-care
  // until a word is pushed).
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ch_data_i;
    end
  end

  // Pointers, occupancy and registered margin; pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_margin <= C_DEPTH_MRG;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_margin <= w_margin_nxt;
    end
  end

endmodule
